seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexed scan controller for a common-anode, NUM_DIGITS-digit 7-segment display. It drives one shared BCD-to-segment decoder, whose output is active-low gfedcba, by stepping a BCD nibble and the matching active-low anode enable through each digit. A blanking gap between digits suppresses ghosting. New display values are double-buffered and committed only at frame boundaries, so the display never tears.

## Interface
- NUM_DIGITS, 4: digits scanned; digit 0 is the least significant nibble.
- SCAN_DIV, 50000: clock cycles per digit slot (blank + on); legal range BLANK_CYC < SCAN_DIV.
- BLANK_CYC, 16: cycles per slot with all anodes off; minimum 1.
- iCLK  in  1  single system clock; all logic on rising edge.
- iRST_N  in  1  reset, asynchronous, active-low.
- iDATA  in  4*NUM_DIGITS  packed BCD value; nibble k belongs to digit k.
- iLOAD  in  1  one-cycle strobe; iDATA is captured on the edge where iLOAD=1.
- iLZB  in  1  leading-zero blanking enable; sampled every cycle.
- oDIG_BCD  out  4  nibble presented to the segment decoder (registered).
- oAN  out  NUM_DIGITS  anode enables, active-low (registered).
- oPEND  out  1  a loaded value is waiting for commit.
- oFRAME  out  1  one-cycle pulse at each frame boundary.

## Operation
- Registers:
  - hold: load buffer.
  - shadow: displayed value.
  - idx: digit index, wraps 0..NUM_DIGITS-1.
  - cnt: slot counter, width $clog2(SCAN_DIV).
  - state: S_BLANK or S_ON.
- Reset values: oAN all 1, oDIG_BCD 0, oPEND 0, oFRAME 0, hold 0, shadow 0, idx 0, cnt 0, state S_BLANK.
- S_BLANK:
  - oAN all 1.
  - oDIG_BCD = shadow[idx], so the decoder settles before the anode turns on.
  - After BLANK_CYC cycles, go to S_ON.
- S_ON:
  - oAN[idx]=0 unless the digit is suppressed; all other anode bits 1.
  - After SCAN_DIV-BLANK_CYC cycles, idx advances and the FSM returns to S_BLANK.
- Suppression: a suppressed digit keeps its anode at 1 for the whole slot and oDIG_BCD=0. A digit is suppressed when either:
  - its shadow nibble is greater than 9, or
  - iLZB=1, idx>0, and every nibble from idx through NUM_DIGITS-1 is 0.
- Frame boundary is the S_ON-to-S_BLANK transition where idx wraps from NUM_DIGITS-1 to 0. On that edge:
  - oFRAME=1 for one cycle.
  - If oPEND=1, shadow<=hold and oPEND<=0.
- Load: iLOAD=1 sets hold<=iDATA and oPEND<=1. A repeated load before commit overwrites hold (last value wins).
- iLOAD on the boundary edge: the commit uses the pre-edge hold; the new iDATA lands in hold and oPEND stays 1. The new value is committed at the next boundary.
- Reset mid-operation: all registers go to reset values immediately, with no clock required. The scan restarts at digit 0 in S_BLANK.

## Timing
- Slot length is exactly SCAN_DIV cycles. Frame period is NUM_DIGITS*SCAN_DIV cycles.
- After iRST_N deasserts, oAN[0] first goes low at the (BLANK_CYC+1)th rising edge. It stays low for SCAN_DIV-BLANK_CYC cycles, followed by BLANK_CYC cycles of all-ones.
- Commit to display latency: the first S_ON of digit 0 after commit shows the new value, BLANK_CYC cycles after oFRAME.
- At most one anode is ever low. No anode is low during any S_BLANK cycle.

## Structure
- Shared package seg_pkg holds:
  - the state enum (S_BLANK, S_ON);
  - the BCD_MAX=9 constant;
  - the all-off anode constant function of NUM_DIGITS.
- Sub-module seg_scan_timer holds cnt, state and idx, and outputs phase, idx and a wrap strobe.
- The top level holds hold/shadow, suppression logic and output registers.
- The segment decoder is instantiated alongside this block, not inside it.

## Test plan
All scenarios use SCAN_DIV=8, BLANK_CYC=2, NUM_DIGITS=4.
- Reset scan, shadow=0, iLZB=0: oAN cycles 1111×2, 1110×6, 1111×2, 1101×6, and on through 0111. oFRAME pulses every 32 cycles and oDIG_BCD=0 throughout.
- iLOAD with 0x1234 at cycle 10: oPEND=1 until the first oFRAME, and that frame still shows 0,0,0,0. The next frame shows oDIG_BCD 4,3,2,1 with oAN[0..3] low in turn.
- iLZB=1:
  - shadow 0x0070: digits 3 and 2 keep their anodes high, digit 1 shows 7, digit 0 shows 0.
  - shadow 0x0000: only oAN[0] ever goes low.
- shadow 0x12A4: oAN[1] stays 1 for its entire slot with oDIG_BCD=0. Digits 0, 2 and 3 show 4, 2, 1.
- Boundary collision: load 0x1111, then load 0x2222 exactly on the boundary edge. The committed value is 0x1111 and oPEND stays 1; 0x2222 is displayed one frame later.
- iRST_N pulsed low mid-S_ON of digit 2: oAN=1111, oPEND=0 and shadow=0 without a clock edge. After release the scan restarts at digit 0 following 2 blank cycles.

Source files
------------

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Shared types and constants for the 7-segment scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

    typedef enum logic [0:0] {
        S_BLANK = 1'b0,
        S_ON    = 1'b1
    } scan_state_e;

    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam int         MAX_DIGITS = 32;

    // Anodes are active-low, so "all off" is a run of ones one per digit.
    function automatic logic [MAX_DIGITS-1:0] an_all_off(input int num_digits);
        logic [MAX_DIGITS-1:0] v;
        v = '0;
        for (int k = 0; k < MAX_DIGITS; k++) begin
            if (k < num_digits) begin
                v[k] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_timer.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_timer
// Description : Slot timer for the scan controller: blank/on phase, digit
//               index and a wrap strobe on the last edge of each frame.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_timer
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 16,
    parameter int IDX_W      = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    output logic             o_phase_on,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_wrap
);

    localparam int               CNT_W        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] c_blank_last = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] c_on_last    = CNT_W'(SCAN_DIV - BLANK_CYC - 1);
    localparam logic [IDX_W-1:0] c_idx_last   = IDX_W'(NUM_DIGITS - 1);

    scan_state_e      r_state_q;
    scan_state_e      w_state_d;
    logic [CNT_W-1:0] r_cnt_q;
    logic [CNT_W-1:0] w_cnt_d;
    logic [IDX_W-1:0] r_idx_q;
    logic [IDX_W-1:0] w_idx_d;
    logic             w_wrap;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state_q <= S_BLANK;
            r_cnt_q   <= '0;
            r_idx_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_idx_q   <= w_idx_d;
        end
    end

    // The counter restarts at every phase change, so each phase counts its own length.
    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q + CNT_W'(1);
        w_idx_d   = r_idx_q;
        w_wrap    = 1'b0;
        case (r_state_q)
            S_BLANK: begin
                if (r_cnt_q == c_blank_last) begin
                    w_state_d = S_ON;
                    w_cnt_d   = '0;
                end
            end
            S_ON: begin
                if (r_cnt_q == c_on_last) begin
                    w_state_d = S_BLANK;
                    w_cnt_d   = '0;
                    if (r_idx_q == c_idx_last) begin
                        w_idx_d = '0;
                        w_wrap  = 1'b1;
                    end else begin
                        w_idx_d = r_idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                w_state_d = S_BLANK;
                w_cnt_d   = '0;
            end
        endcase
    end

    assign o_phase_on = (r_state_q == S_ON);
    assign o_idx      = r_idx_q;
    assign o_wrap     = w_wrap;

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_ctrl
// Description : Multiplexed common-anode 7-segment scan controller with
//               blanking gaps, leading-zero blanking and frame-synchronous
//               double-buffered display updates.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 16
) (
    input  logic                    iCLK,
    input  logic                    iRST_N,
    input  logic [4*NUM_DIGITS-1:0] iDATA,
    input  logic                    iLOAD,
    input  logic                    iLZB,
    output logic [3:0]              oDIG_BCD,
    output logic [NUM_DIGITS-1:0]   oAN,
    output logic                    oPEND,
    output logic                    oFRAME
);

    localparam int                    IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int                    DATA_W   = 4 * NUM_DIGITS;
    localparam logic [MAX_DIGITS-1:0] c_an_all = an_all_off(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] c_an_off = c_an_all[NUM_DIGITS-1:0];

    logic                  w_phase_on;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_wrap;

    logic [DATA_W-1:0]     r_hold_q;
    logic [DATA_W-1:0]     w_hold_d;
    logic [DATA_W-1:0]     r_shadow_q;
    logic [DATA_W-1:0]     w_shadow_d;
    logic                  r_pend_q;
    logic                  w_pend_d;
    logic                  r_frame_q;
    logic                  w_frame_d;
    logic [NUM_DIGITS-1:0] r_an_q;
    logic [NUM_DIGITS-1:0] w_an_d;
    logic [3:0]            r_dig_q;
    logic [3:0]            w_dig_d;

    logic [3:0]            w_nib_cur;
    logic                  w_upper_zero;
    logic                  w_supp;

    seg_scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV),
        .BLANK_CYC  (BLANK_CYC),
        .IDX_W      (IDX_W)
    ) u_timer (
        .i_clk      (iCLK),
        .i_rst_n    (iRST_N),
        .o_phase_on (w_phase_on),
        .o_idx      (w_idx),
        .o_wrap     (w_wrap)
    );

    // Current nibble, and whether it and every more significant nibble are zero.
    always_comb begin
        w_nib_cur    = 4'd0;
        w_upper_zero = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k == int'(w_idx)) begin
                w_nib_cur = r_shadow_q[4*k +: 4];
            end
            if ((k >= int'(w_idx)) && (r_shadow_q[4*k +: 4] != 4'd0)) begin
                w_upper_zero = 1'b0;
            end
        end
        w_supp = (w_nib_cur > BCD_MAX) || (iLZB && (w_idx != '0) && w_upper_zero);
    end

    always_comb begin
        w_an_d  = c_an_off;
        w_dig_d = w_supp ? 4'd0 : w_nib_cur;
        if (w_phase_on && !w_supp) begin
            w_an_d[w_idx] = 1'b0;
        end

        w_frame_d  = w_wrap;
        w_hold_d   = r_hold_q;
        w_shadow_d = r_shadow_q;
        w_pend_d   = r_pend_q;
        // Commit first so a load on the boundary edge is kept for the next frame.
        if (w_wrap && r_pend_q) begin
            w_shadow_d = r_hold_q;
            w_pend_d   = 1'b0;
        end
        if (iLOAD) begin
            w_hold_d = iDATA;
            w_pend_d = 1'b1;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_hold_q   <= '0;
            r_shadow_q <= '0;
            r_pend_q   <= 1'b0;
            r_frame_q  <= 1'b0;
            r_an_q     <= c_an_off;
            r_dig_q    <= 4'd0;
        end else begin
            r_hold_q   <= w_hold_d;
            r_shadow_q <= w_shadow_d;
            r_pend_q   <= w_pend_d;
            r_frame_q  <= w_frame_d;
            r_an_q     <= w_an_d;
            r_dig_q    <= w_dig_d;
        end
    end

    assign oAN      = r_an_q;
    assign oDIG_BCD = r_dig_q;
    assign oPEND    = r_pend_q;
    assign oFRAME   = r_frame_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_ctrl
// Description : Self-checking bench for seg_scan_ctrl against a frame-position
//               reference model (SCAN_DIV=8, BLANK_CYC=2, NUM_DIGITS=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int SD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * SD;

    logic        iCLK;
    logic        iRST_N;
    logic [15:0] iDATA;
    logic        iLOAD;
    logic        iLZB;
    logic [3:0]  oDIG_BCD;
    logic [3:0]  oAN;
    logic        oPEND;
    logic        oFRAME;
    logic [9:0]  obs;

    int          n_cmp;
    int          n_fail;
    int          e;
    logic [15:0] shadow_m;
    logic [15:0] hold_m;
    logic        pend_m;

    seg_scan_ctrl #(
        .NUM_DIGITS (ND),
        .SCAN_DIV   (SD),
        .BLANK_CYC  (BC)
    ) dut (
        .iCLK     (iCLK),
        .iRST_N   (iRST_N),
        .iDATA    (iDATA),
        .iLOAD    (iLOAD),
        .iLZB     (iLZB),
        .oDIG_BCD (oDIG_BCD),
        .oAN      (oAN),
        .oPEND    (oPEND),
        .oFRAME   (oFRAME)
    );

    assign obs = {oAN, oDIG_BCD, oFRAME, oPEND};

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    function automatic void model_reset();
        e        = 0;
        shadow_m = 16'h0;
        hold_m   = 16'h0;
        pend_m   = 1'b0;
    endfunction

    // Expected {oAN, oDIG_BCD, oFRAME, oPEND} after the next rising edge,
    // derived from the position of that edge within the frame.
    function automatic logic [9:0] model_edge();
        int         p;
        int         d;
        int         s;
        logic [3:0] nib;
        logic [3:0] an;
        logic [3:0] dig;
        logic       supp;
        logic       fr;
        e++;
        p    = (e - 1) % FRAME;
        d    = p / SD;
        s    = p % SD;
        nib  = shadow_m[d*4 +: 4];
        supp = (nib > 4'd9) || (iLZB && (d > 0) && ((shadow_m >> (4*d)) == 16'h0));
        an   = 4'hF;
        if ((s >= BC) && !supp) an[d] = 1'b0;
        dig  = supp ? 4'd0 : nib;
        fr   = (p == FRAME - 1);
        if (fr && pend_m) begin
            shadow_m = hold_m;
            pend_m   = 1'b0;
        end
        if (iLOAD) begin
            hold_m = iDATA;
            pend_m = 1'b1;
        end
        return {an, dig, fr, pend_m};
    endfunction

    task automatic test_reset();
        iRST_N = 1'b1;
        iLOAD  = 1'b0;
        iDATA  = 16'h0;
        iLZB   = 1'b0;
        #2 iRST_N = 1'b0;
        #2;
        n_cmp++;
        if (obs !== 10'b1111_0000_0_0) begin
            n_fail++;
            $display("FAIL reset_async actual=%b required=%b", obs, 10'b1111_0000_0_0);
        end
        repeat (2) @(posedge iCLK);
        #1;
        n_cmp++;
        if (obs !== 10'b1111_0000_0_0 || dut.r_shadow_q !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_held actual=%b shadow=%h required=%b shadow=0000",
                     obs, dut.r_shadow_q, 10'b1111_0000_0_0);
        end
        iRST_N = 1'b1;
        model_reset();
    endtask

    task automatic test_scan();
        logic [9:0] exp;
        for (int c = 0; c < 3 * FRAME; c++) begin
            iLOAD = 1'b0;
            exp = model_edge();
            @(posedge iCLK); #1;
            n_cmp++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL scan e=%0d actual=%b required=%b", e, obs, exp);
            end
        end
    endtask

    task automatic test_load();
        logic [9:0] exp;
        bit         done;
        done = 1'b0;
        for (int c = 0; c < 4 * FRAME; c++) begin
            iLOAD = 1'b0;
            if (!done && (e % FRAME == 9)) begin
                iLOAD = 1'b1;
                iDATA = 16'h1234;
                done  = 1'b1;
            end
            exp = model_edge();
            @(posedge iCLK); #1;
            n_cmp++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL load e=%0d actual=%b required=%b", e, obs, exp);
            end
        end
        iLOAD = 1'b0;
    endtask

    task automatic test_lzb(input logic [15:0] val);
        logic [9:0] exp;
        bit         done;
        done = 1'b0;
        iLZB = 1'b1;
        for (int c = 0; c < 4 * FRAME + 4; c++) begin
            iLOAD = 1'b0;
            if (!done && (e % FRAME == 4)) begin
                iLOAD = 1'b1;
                iDATA = val;
                done  = 1'b1;
            end
            exp = model_edge();
            @(posedge iCLK); #1;
            n_cmp++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL lzb_%h e=%0d actual=%b required=%b", val, e, obs, exp);
            end
        end
        iLOAD = 1'b0;
        iLZB  = 1'b0;
    endtask

    task automatic test_invalid();
        logic [9:0] exp;
        bit         done;
        done = 1'b0;
        for (int c = 0; c < 4 * FRAME + 4; c++) begin
            iLOAD = 1'b0;
            if (!done && (e % FRAME == 12)) begin
                iLOAD = 1'b1;
                iDATA = 16'h12A4;
                done  = 1'b1;
            end
            exp = model_edge();
            @(posedge iCLK); #1;
            n_cmp++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL invalid_nibble e=%0d actual=%b required=%b", e, obs, exp);
            end
        end
        iLOAD = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp;
        bit         l1;
        bit         l2;
        bit         just_hit;
        l1 = 1'b0;
        l2 = 1'b0;
        for (int c = 0; c < 5 * FRAME; c++) begin
            iLOAD    = 1'b0;
            just_hit = 1'b0;
            if (!l1 && (e % FRAME == 5)) begin
                iLOAD = 1'b1;
                iDATA = 16'h1111;
                l1    = 1'b1;
            end else if (l1 && !l2 && (e % FRAME == FRAME - 1)) begin
                iLOAD    = 1'b1;
                iDATA    = 16'h2222;
                l2       = 1'b1;
                just_hit = 1'b1;
            end
            exp = model_edge();
            @(posedge iCLK); #1;
            n_cmp++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL collision e=%0d actual=%b required=%b", e, obs, exp);
            end
            if (just_hit) begin
                n_cmp++;
                if (dut.r_shadow_q !== 16'h1111 || oPEND !== 1'b1 || oFRAME !== 1'b1) begin
                    n_fail++;
                    $display("FAIL collision_edge actual shadow=%h pend=%b frame=%b required shadow=1111 pend=1 frame=1",
                             dut.r_shadow_q, oPEND, oFRAME);
                end
            end
        end
        iLOAD = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [9:0] exp;
        bit         loaded;
        loaded = 1'b0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            if (loaded && (e % FRAME == 20)) break;
            iLOAD = 1'b0;
            if (!loaded && (e % FRAME == 10)) begin
                iLOAD  = 1'b1;
                iDATA  = 16'h9999;
                loaded = 1'b1;
            end
            exp = model_edge();
            @(posedge iCLK); #1;
            n_cmp++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL pre_reset e=%0d actual=%b required=%b", e, obs, exp);
            end
        end
        iLOAD = 1'b0;
        #2 iRST_N = 1'b0;
        #1;
        n_cmp++;
        if (obs !== 10'b1111_0000_0_0 || dut.r_shadow_q !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_mid actual=%b shadow=%h required=%b shadow=0000",
                     obs, dut.r_shadow_q, 10'b1111_0000_0_0);
        end
        @(posedge iCLK); #1;
        iRST_N = 1'b1;
        model_reset();
        for (int c = 0; c < FRAME + 8; c++) begin
            exp = model_edge();
            @(posedge iCLK); #1;
            n_cmp++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL restart e=%0d actual=%b required=%b", e, obs, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [9:0]  exp;
        logic [15:0] d;
        for (int c = 0; c < 25 * FRAME; c++) begin
            for (int k = 0; k < ND; k++) begin
                d[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 11));
            end
            iDATA = d;
            iLOAD = ($urandom_range(0, 23) == 0);
            if ($urandom_range(0, 39) == 0) iLZB = ~iLZB;
            exp = model_edge();
            @(posedge iCLK); #1;
            n_cmp++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL random e=%0d data=%h lzb=%b actual=%b required=%b", e, iDATA, iLZB, obs, exp);
            end
        end
        iLOAD = 1'b0;
        iLZB  = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        model_reset();
        test_reset();
        test_scan();
        test_load();
        test_lzb(16'h0070);
        test_lzb(16'h0000);
        test_invalid();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
